// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift unit: shift modes and FSM states.
// Optional rotate support is enabled by SEQ_SHIFT_ROTATE_EN in the design files.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of WIDTH bits by amt (0..STEP) positions, with carry-out.
// The rot input selects rotate for LSL/LSR (driven only when SEQ_SHIFT_ROTATE_EN is defined).
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_t      mode,
  input  logic             rot,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] v_s;
  logic             c_s;

  // apply up to STEP single-bit steps; carry tracks the last bit pushed out
  always_comb begin
    v_s = data;
    c_s = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (AW'(i) < amt) begin
        case (mode)
          SH_LSL: begin
            c_s = v_s[WIDTH-1];
            v_s = {v_s[WIDTH-2:0], rot & v_s[WIDTH-1]};
          end
          SH_LSR: begin
            c_s = v_s[0];
            v_s = {rot & v_s[0], v_s[WIDTH-1:1]};
          end
          SH_ASR: begin
            c_s = v_s[0];
            v_s = {v_s[WIDTH-1], v_s[WIDTH-1:1]};
          end
          default: begin
            c_s = c_s;
            v_s = v_s;
          end
        endcase
      end else begin
        c_s = c_s;
        v_s = v_s;
      end
    end
  end

  assign result = v_s;
  assign carry  = c_s;

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: valid/ready request in, STEP bits shifted per cycle, valid/ready result out.
// Define SEQ_SHIFT_ROTATE_EN to add the in_rot port (rotate for LSL/LSR).
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [AW-1:0]    in_amt,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH - 1);
  localparam logic [AW-1:0] STEP_L  = AW'(STEP);

  shift_state_t     state_r, state_n;
  shift_mode_t      mode_r;
  logic             rot_r;
  logic [AW-1:0]    rem_r;
  logic [WIDTH-1:0] data_r;
  logic             carry_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [AW-1:0]    amt_sat_s;
  logic [AW-1:0]    k_s;
  logic [WIDTH-1:0] step_res_s;
  logic             step_carry_s;
  logic             rot_in_s;

`ifdef SEQ_SHIFT_ROTATE_EN
  assign rot_in_s = in_rot;
`else
  assign rot_in_s = 1'b0;
`endif

  assign amt_sat_s = (in_amt > AMT_MAX) ? AMT_MAX : in_amt;
  assign k_s       = (rem_r > STEP_L) ? STEP_L : rem_r;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .data   (data_r),
    .mode   (mode_r),
    .rot    (rot_r),
    .amt    (k_s),
    .result (step_res_s),
    .carry  (step_carry_s)
  );

  // next-state decode; DONE is left only once the result has actually been presented
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          if ((amt_sat_s == {AW{1'b0}}) || (shift_mode_t'(in_mode) == SH_NONE)) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_SHIFT;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_r == k_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, handshake flags and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_r      <= SH_NONE;
      rot_r       <= 1'b0;
      rem_r       <= {AW{1'b0}};
      data_r      <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == ST_IDLE);
      // a zero-work request spends one cycle in DONE before valid, so latency is never below one
      out_valid_r <= (state_n == ST_DONE) && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            data_r  <= in_data;
            mode_r  <= shift_mode_t'(in_mode);
            rot_r   <= rot_in_s;
            rem_r   <= amt_sat_s;
            carry_r <= 1'b0;
          end else begin
            data_r  <= data_r;
            carry_r <= carry_r;
          end
        end
        ST_SHIFT: begin
          data_r  <= step_res_s;
          carry_r <= step_carry_s;
          rem_r   <= rem_r - k_s;
        end
        default: begin
          data_r  <= data_r;
          carry_r <= carry_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = data_r;
  assign out_carry = carry_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: STEP=1 and STEP=4 instances, expected values hand-computed.
// Rotate vectors are compiled only when SEQ_SHIFT_ROTATE_EN is defined.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic [1:0]  in_mode = 2'b00;
  logic [3:0]  in_amt = 4'd0;
  logic        out_ready = 1'b0;
  logic        in_valid1 = 1'b0, in_valid4 = 1'b0;
  logic        in_ready1, in_ready4, out_valid1, out_valid4, out_carry1, out_carry4;
  logic [15:0] out_data1, out_data4;
`ifdef SEQ_SHIFT_ROTATE_EN
  logic        in_rot = 1'b0;
`endif

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
`ifdef SEQ_SHIFT_ROTATE_EN
    .in_rot(in_rot),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_carry(out_carry1)
  );

  seq_shift_unit #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
`ifdef SEQ_SHIFT_ROTATE_EN
    .in_rot(in_rot),
`endif
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_carry(out_carry4)
  );

  // issue one request and count edges after the accept edge until out_valid (0 = never seen)
  task automatic send(input bit sel4, input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                      output int lat, output logic [15:0] dat, output logic car);
    @(negedge clk);
    in_data = d; in_mode = m; in_amt = a;
    if (sel4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((sel4 ? out_valid4 : out_valid1) === 1'b1) begin
        lat = i;
        break;
      end
    end
    dat = sel4 ? out_data4 : out_data1;
    car = sel4 ? out_carry4 : out_carry1;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compared++; if (in_ready1 !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
    compared++; if (out_valid1 !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
    compared++; if (out_data1 !== 16'h0000) begin failed++; $display("FAIL reset_out_data got %h want 0000", out_data1); end
    compared++; if (out_carry4 !== 1'b0) begin failed++; $display("FAIL reset_out_carry got %b want 0", out_carry4); end
  endtask

  task automatic test_lsl();
    int lat; logic [15:0] d; logic c;
    send(1'b0, 16'h8001, 2'b01, 4'd1, lat, d, c);
    compared++; if (d !== 16'h0002) begin failed++; $display("FAIL lsl1_data got %h want 0002", d); end
    compared++; if (c !== 1'b1) begin failed++; $display("FAIL lsl1_carry got %b want 1", c); end
    compared++; if (lat !== 1) begin failed++; $display("FAIL lsl1_latency got %0d want 1", lat); end
    take();
  endtask

  task automatic test_lsr();
    int lat; logic [15:0] d; logic c;
    send(1'b0, 16'h00F0, 2'b10, 4'd4, lat, d, c);
    compared++; if (d !== 16'h000F) begin failed++; $display("FAIL lsr4_data got %h want 000f", d); end
    compared++; if (c !== 1'b0) begin failed++; $display("FAIL lsr4_carry got %b want 0", c); end
    compared++; if (lat !== 4) begin failed++; $display("FAIL lsr4_latency got %0d want 4", lat); end
    take();
    send(1'b0, 16'h00F0, 2'b10, 4'd5, lat, d, c);
    compared++; if (d !== 16'h0007) begin failed++; $display("FAIL lsr5_data got %h want 0007", d); end
    compared++; if (c !== 1'b1) begin failed++; $display("FAIL lsr5_carry got %b want 1", c); end
    compared++; if (lat !== 5) begin failed++; $display("FAIL lsr5_latency got %0d want 5", lat); end
    take();
  endtask

  task automatic test_asr_none();
    int lat; logic [15:0] d; logic c;
    send(1'b0, 16'h8000, 2'b11, 4'd15, lat, d, c);
    compared++; if (d !== 16'hFFFF) begin failed++; $display("FAIL asr15_data got %h want ffff", d); end
    compared++; if (c !== 1'b0) begin failed++; $display("FAIL asr15_carry got %b want 0", c); end
    compared++; if (lat !== 15) begin failed++; $display("FAIL asr15_latency got %0d want 15", lat); end
    take();
    send(1'b0, 16'h1234, 2'b00, 4'd7, lat, d, c);
    compared++; if (d !== 16'h1234) begin failed++; $display("FAIL none_data got %h want 1234", d); end
    compared++; if (c !== 1'b0) begin failed++; $display("FAIL none_carry got %b want 0", c); end
    compared++; if (lat !== 1) begin failed++; $display("FAIL none_latency got %0d want 1", lat); end
    take();
  endtask

  task automatic test_backpressure();
    int lat; int seen; logic [15:0] d; logic c;
    send(1'b0, 16'h00F0, 2'b10, 4'd5, lat, d, c);
    // offer a competing request while the result is stalled
    @(negedge clk);
    in_data = 16'hAAAA; in_mode = 2'b01; in_amt = 4'd1; in_valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++; if (out_valid1 !== 1'b1) begin failed++; $display("FAIL bp_valid cyc%0d got %b want 1", i, out_valid1); end
      compared++; if (out_data1 !== 16'h0007) begin failed++; $display("FAIL bp_data cyc%0d got %h want 0007", i, out_data1); end
      compared++; if (out_carry1 !== 1'b1) begin failed++; $display("FAIL bp_carry cyc%0d got %b want 1", i, out_carry1); end
      compared++; if (in_ready1 !== 1'b0) begin failed++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready1); end
    end
    take();
    in_valid1 = 1'b0;
    compared++; if (in_ready1 !== 1'b1) begin failed++; $display("FAIL bp_ready_after_take got %b want 1", in_ready1); end
    compared++; if (out_valid1 !== 1'b0) begin failed++; $display("FAIL bp_valid_after_take got %b want 0", out_valid1); end
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (out_valid1 === 1'b1) seen++; end
    compared++; if (seen !== 0) begin failed++; $display("FAIL bp_no_stray_accept got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] d; logic c;
    send(1'b0, 16'h0F0F, 2'b01, 4'd4, lat, d, c);
    compared++; if (d !== 16'hF0F0) begin failed++; $display("FAIL b2b_data got %h want f0f0", d); end
    compared++; if (c !== 1'b0) begin failed++; $display("FAIL b2b_carry got %b want 0", c); end
    compared++; if (lat !== 4) begin failed++; $display("FAIL b2b_latency got %0d want 4", lat); end
    take();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    in_data = 16'hFFFF; in_mode = 2'b01; in_amt = 4'd10; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared++; if (in_ready1 !== 1'b1) begin failed++; $display("FAIL rstmid_in_ready got %b want 1", in_ready1); end
    compared++; if (out_valid1 !== 1'b0) begin failed++; $display("FAIL rstmid_out_valid got %b want 0", out_valid1); end
    compared++; if (out_data1 !== 16'h0000) begin failed++; $display("FAIL rstmid_out_data got %h want 0000", out_data1); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid1 === 1'b1) seen++; end
    compared++; if (seen !== 0) begin failed++; $display("FAIL rstmid_no_result got %0d want 0", seen); end
  endtask

  task automatic test_step4();
    int lat; logic [15:0] d; logic c;
    send(1'b1, 16'h0001, 2'b01, 4'd9, lat, d, c);
    compared++; if (d !== 16'h0200) begin failed++; $display("FAIL s4_lsl9_data got %h want 0200", d); end
    compared++; if (c !== 1'b0) begin failed++; $display("FAIL s4_lsl9_carry got %b want 0", c); end
    compared++; if (lat !== 3) begin failed++; $display("FAIL s4_lsl9_latency got %0d want 3", lat); end
    take();
    send(1'b1, 16'h00F0, 2'b10, 4'd5, lat, d, c);
    compared++; if (d !== 16'h0007) begin failed++; $display("FAIL s4_lsr5_data got %h want 0007", d); end
    compared++; if (c !== 1'b1) begin failed++; $display("FAIL s4_lsr5_carry got %b want 1", c); end
    compared++; if (lat !== 2) begin failed++; $display("FAIL s4_lsr5_latency got %0d want 2", lat); end
    take();
    send(1'b1, 16'h8000, 2'b11, 4'd15, lat, d, c);
    compared++; if (d !== 16'hFFFF) begin failed++; $display("FAIL s4_asr15_data got %h want ffff", d); end
    compared++; if (lat !== 4) begin failed++; $display("FAIL s4_asr15_latency got %0d want 4", lat); end
    take();
  endtask

`ifdef SEQ_SHIFT_ROTATE_EN
  task automatic test_rotate();
    int lat; logic [15:0] d; logic c;
    in_rot = 1'b1;
    send(1'b1, 16'h0001, 2'b10, 4'd1, lat, d, c);
    compared++; if (d !== 16'h8000) begin failed++; $display("FAIL rotr_data got %h want 8000", d); end
    compared++; if (c !== 1'b1) begin failed++; $display("FAIL rotr_carry got %b want 1", c); end
    take();
    send(1'b0, 16'h8001, 2'b01, 4'd1, lat, d, c);
    compared++; if (d !== 16'h0003) begin failed++; $display("FAIL rotl_data got %h want 0003", d); end
    compared++; if (c !== 1'b1) begin failed++; $display("FAIL rotl_carry got %b want 1", c); end
    take();
    send(1'b0, 16'h8000, 2'b11, 4'd1, lat, d, c);
    compared++; if (d !== 16'hC000) begin failed++; $display("FAIL rot_asr_data got %h want c000", d); end
    take();
    in_rot = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_lsl();
    test_lsr();
    test_asr_none();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_step4();
`ifdef SEQ_SHIFT_ROTATE_EN
    test_rotate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
